// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between the execute stage and the mul/div unit
interface muldiv_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             flush;
    logic             busy;
    logic             resp_valid;
    logic [WIDTH-1:0] result;

    modport master (
        output req_valid, op, operand_a, operand_b, flush,
        input  req_ready, busy, resp_valid, result
    );

    modport slave (
        input  req_valid, op, operand_a, operand_b, flush,
        output req_ready, busy, resp_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int N  = WIDTH / UNROLL;
    localparam int CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic [CW-1:0]      count_q, count_d;

    logic               is_div, a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               special;
    logic [WIDTH-1:0]   special_val;
    logic [2*WIDTH-1:0] acc_v, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_val;

    // acc low half holds the multiplier; high half accumulates, shifting right each step
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // acc = {remainder, dividend/quotient}; quotient bits enter at the bottom
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   dvs);
        logic [WIDTH:0] rem_sh;
        logic [WIDTH:0] diff;
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, dvs};
        if (diff[WIDTH])
            return {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    endfunction

    always_comb begin
        is_div   = bus.op[2];
        a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
        b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
        a_neg    = a_signed && bus.operand_a[WIDTH-1];
        b_neg    = b_signed && bus.operand_b[WIDTH-1];
        a_mag    = a_neg ? -bus.operand_a : bus.operand_a;
        b_mag    = b_neg ? -bus.operand_b : bus.operand_b;

        special     = 1'b0;
        special_val = '0;
        if (is_div && bus.operand_b == '0) begin
            special     = 1'b1;
            special_val = bus.op[1] ? bus.operand_a : '1;
        end else if (is_div && !bus.op[0] && bus.operand_a == MIN_INT && bus.operand_b == '1) begin
            special     = 1'b1;
            special_val = bus.op[1] ? '0 : MIN_INT;
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (op_q[2])
            fix_val = op_q[1] ? rem_fix : quo_fix;
        else
            fix_val = (op_q[1:0] == 2'd0) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        result_d  = result_q;
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        count_d   = count_q;
        acc_v     = acc_q;

        if (state_q != IDLE && bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && !bus.flush) begin
                        op_d      = bus.op;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        if (special) begin
                            result_d = special_val;
                            state_d  = DONE;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
                            opb_d   = is_div ? b_mag : a_mag;
                            count_d = '0;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    for (int i = 0; i < UNROLL; i++)
                        acc_v = op_q[2] ? div_step(acc_v, opb_q) : mul_step(acc_v, opb_q);
                    acc_d   = acc_v;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(N - 1))
                        state_d = FIXUP;
                end
                FIXUP: begin
                    result_d = fix_val;
                    state_d  = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            count_q   <= count_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = (state_q == DONE) && !bus.flush;
    assign bus.result     = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (UNROLL=1 and UNROLL=4 instances)
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_if #(.WIDTH(32)) bus  ();
    muldiv_if #(.WIDTH(32)) bus4 ();

    muldiv_unit #(.WIDTH(32), .UNROLL(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
    muldiv_unit #(.WIDTH(32), .UNROLL(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t;
    } exp_t;

    exp_t sb[$];
    exp_t sb4[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.resp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got result %h expected no response", bus.result);
            end else begin
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("latency", 32'(cyc - e.t), 32'(e.lat));
                check("ready_in_done", {31'd0, bus.req_ready}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && bus4.resp_valid) begin
            if (sb4.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp_u4: got result %h expected no response", bus4.result);
            end else begin
                e = sb4.pop_front();
                check("result_u4", bus4.result, e.res);
                check("latency_u4", 32'(cyc - e.t), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input bit expect_resp);
        int w = 0;
        @(posedge clk); #1;
        while (!bus.req_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got req_ready 0 expected 1");
            return;
        end
        bus.req_valid = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        if (expect_resp) sb.push_back('{res, lat, cyc});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.operand_a = 32'hDEAD_BEEF;
        bus.operand_b = 32'h1234_5678;
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || sb4.size() != 0) && w < 300) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0 || sb4.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size() + sb4.size());
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.op         = 3'd0;
        bus.operand_a  = '0;
        bus.operand_b  = '0;
        bus.flush      = 1'b0;
        bus4.req_valid = 1'b0;
        bus4.op        = 3'd0;
        bus4.operand_a = '0;
        bus4.operand_b = '0;
        bus4.flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("reset_result", bus.result, 32'd0);

        issue(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
        issue(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b1);
        issue(3'd0, 32'd0,          32'd0,         32'd0,         34, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 1'b1);
        issue(3'd5, 32'd100,        32'd7,         32'd14,        34, 1'b1);
        issue(3'd7, 32'd100,        32'd7,         32'd2,         34, 1'b1);
        issue(3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  1'b1);
        issue(3'd6, 32'd5,          32'd0,         32'd5,         1,  1'b1);
        issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b1);
        issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  1'b1);
        issue(3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF, 1,  1'b1);
        issue(3'd7, 32'd9,          32'd0,         32'd9,         1,  1'b1);
        drain();

        // flush in IDLE must block acceptance
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.op        = 3'd5;
        bus.operand_a = 32'd50;
        bus.operand_b = 32'd3;
        bus.flush     = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("flush_idle_busy", {31'd0, bus.busy}, 32'd0);

        // flush in CALC cycle 10
        issue(3'd5, 32'd1000, 32'd7, 32'd0, 0, 1'b0);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_calc_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_calc_result", bus.result, 32'd9);
        repeat (40) @(posedge clk);
        issue(3'd5, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        drain();

        // asynchronous reset mid-CALC
        issue(3'd0, 32'd3, 32'd5, 32'd0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // UNROLL=4 instance
        @(posedge clk); #1;
        bus4.req_valid = 1'b1;
        bus4.op        = 3'd0;
        bus4.operand_a = 32'd7;
        bus4.operand_b = 32'hFFFF_FFFD;
        sb4.push_back('{32'hFFFF_FFEB, 10, cyc});
        @(posedge clk); #1;
        bus4.req_valid = 1'b0;
        bus4.operand_a = 32'hDEAD_BEEF;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
